// File: rtl/sha256_arbiter.sv
// Message-granular round-robin arbiter feeding byte streams to a shared SHA-256 core.
// A tag FIFO records each grant so that core results are routed back to their requesters in order.
module sha256_arbiter #(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           s_tvalid,
  output logic [NREQ-1:0]           s_tready,
  input  logic [NREQ-1:0]           s_tlast,
  input  logic [NREQ*32-1:0]        s_tid,
  input  logic [NREQ*8-1:0]         s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic [31:0]               m_tid,
  output logic [7:0]                m_tdata,
  input  logic                      c_ovalid,
  input  logic [31:0]               c_oid,
  input  logic [60:0]               c_olen,
  input  logic [255:0]              c_osha,
  output logic                      r_valid,
  output logic [$clog2(NREQ)-1:0]   r_src,
  output logic [31:0]               r_id,
  output logic [60:0]               r_len,
  output logic [255:0]              r_sha,
  output logic                      tag_err
);

  localparam int SW = $clog2(NREQ);
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   gnt_q, gnt_d;
  logic [SW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [SW-1:0]   tag_mem_q [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_s, pop_s;
  logic [SW-1:0]   head_tag_s;

  logic [NREQ-1:0] gnt_oh_s;
  logic            sel_valid_s, sel_last_s;
  logic [31:0]     sel_tid_s;
  logic [7:0]      sel_data_s;

  logic            r_valid_q;
  logic [SW-1:0]   r_src_q;
  logic [31:0]     r_id_q;
  logic [60:0]     r_len_q;
  logic [255:0]    r_sha_q;
  logic            tag_err_q;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [SW-1:0] ptr);
    logic [SW-1:0] sel;
    logic [SW-1:0] idx;
    logic          found;
    sel   = {SW{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = SW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  // Select the granted requester's stream with a one-hot AND-OR mux.
  always_comb begin
    gnt_oh_s   = {NREQ{1'b0}};
    sel_tid_s  = 32'd0;
    sel_data_s = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh_s[i] = (gnt_q == SW'(i));
    end
    sel_valid_s = |(s_tvalid & gnt_oh_s);
    sel_last_s  = |(s_tlast & gnt_oh_s);
    for (int i = 0; i < NREQ; i++) begin
      sel_tid_s  = sel_tid_s  | (s_tid[i*32 +: 32] & {32{gnt_oh_s[i]}});
      sel_data_s = sel_data_s | (s_tdata[i*8 +: 8] & {8{gnt_oh_s[i]}});
    end
  end

  // Arbitration FSM: grant decision in IDLE, pass-through in BUSY.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    push_s   = 1'b0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tid    = 32'd0;
    m_tdata  = 8'd0;
    s_tready = {NREQ{1'b0}};
    case (state_q)
      IDLE: begin
        // Grant check uses the count before any same-cycle pop.
        if ((|s_tvalid) && (cnt_q < CW'(TAG_DEPTH))) begin
          gnt_d   = rr_pick(s_tvalid, rr_ptr_q);
          push_s  = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        m_tvalid = sel_valid_s;
        m_tlast  = sel_last_s;
        m_tid    = sel_tid_s;
        m_tdata  = sel_data_s;
        s_tready = gnt_oh_s & {NREQ{m_tready}};
        if (sel_valid_s && m_tready && sel_last_s) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_q == SW'(NREQ - 1)) ? {SW{1'b0}} : gnt_q + SW'(1);
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      gnt_q    <= {SW{1'b0}};
      rr_ptr_q <= {SW{1'b0}};
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign pop_s      = c_ovalid && (cnt_q != CW'(0));
  assign head_tag_s = tag_mem_q[rd_ptr_q];

  // Tag occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag FIFO storage and pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= {SW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_q[wr_ptr_q] <= gnt_d;
        wr_ptr_q            <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // Registered result routing; an orphan result reports source 0 and latches tag_err.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_q <= 1'b0;
      r_src_q   <= {SW{1'b0}};
      r_id_q    <= 32'd0;
      r_len_q   <= 61'd0;
      r_sha_q   <= 256'd0;
      tag_err_q <= 1'b0;
    end else begin
      r_valid_q <= c_ovalid;
      tag_err_q <= tag_err_q | (c_ovalid & ~pop_s);
      if (c_ovalid) begin
        r_src_q <= pop_s ? head_tag_s : {SW{1'b0}};
        r_id_q  <= c_oid;
        r_len_q <= c_olen;
        r_sha_q <= c_osha;
      end
    end
  end

  assign r_valid = r_valid_q;
  assign r_src   = r_src_q;
  assign r_id    = r_id_q;
  assign r_len   = r_len_q;
  assign r_sha   = r_sha_q;
  assign tag_err = tag_err_q;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Directed bench for sha256_arbiter: inputs change 2 time units after the rising edge,
// outputs are sampled 1 unit later.
module tb_sha256_arbiter;

  logic         clk;
  logic         rstn;
  logic [3:0]   s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tid;
  logic [31:0]  s_tdata;
  logic         m_tvalid, m_tready, m_tlast;
  logic [31:0]  m_tid;
  logic [7:0]   m_tdata;
  logic         c_ovalid;
  logic [31:0]  c_oid;
  logic [60:0]  c_olen;
  logic [255:0] c_osha;
  logic         r_valid;
  logic [1:0]   r_src;
  logic [31:0]  r_id;
  logic [60:0]  r_len;
  logic [255:0] r_sha;
  logic         tag_err;

  int checks;
  int errors;

  localparam logic [255:0] ABC_SHA =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  sha256_arbiter #(.NREQ(4), .TAG_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tid(s_tid), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tdata(m_tdata),
    .c_ovalid(c_ovalid), .c_oid(c_oid), .c_olen(c_olen), .c_osha(c_osha),
    .r_valid(r_valid), .r_src(r_src), .r_id(r_id), .r_len(r_len), .r_sha(r_sha),
    .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rstn     = 1'b0;
    s_tvalid = 4'b0000;
    s_tlast  = 4'b0000;
    c_ovalid = 1'b0;
    m_tready = 1'b1;
    s_tid    = {32'd103, 32'd102, 32'd101, 32'd100};
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 4'hF; s_tlast = 4'hF; m_tready = 1'b1; c_ovalid = 1'b0;
    s_tid = {32'd103, 32'd102, 32'd101, 32'd100}; s_tdata = 32'h0;
    c_oid = 32'd0; c_olen = 61'd0; c_osha = 256'd0;
    tick(); tick();
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_tready: got %b expected 0000", s_tready); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b expected 0", r_valid); end
    checks++; if (r_src !== 2'd0) begin errors++; $display("FAIL reset_r_src: got %0d expected 0", r_src); end
    checks++; if (r_sha !== 256'd0) begin errors++; $display("FAIL reset_r_sha: got %h expected 0", r_sha); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL reset_tag_err: got %b expected 0", tag_err); end
    s_tvalid = 4'b0000;
    rstn = 1'b1;
  endtask

  task automatic test_single_abc();
    logic [23:0] abc;
    abc = 24'h616263;
    do_reset();
    s_tid[63:32] = 32'd111;
    s_tvalid = 4'b0010; s_tlast = 4'b0000; s_tdata[15:8] = abc[23:16];
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL abc_idle_cycle: m_tvalid got %b expected 0", m_tvalid); end
    tick();
    for (int b = 0; b < 3; b++) begin
      s_tdata[15:8] = abc[23-8*b -: 8];
      s_tlast[1]    = (b == 2);
      #1;
      checks++; if (s_tready !== 4'b0010) begin errors++; $display("FAIL abc_s_tready beat %0d: got %b expected 0010", b, s_tready); end
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== abc[23-8*b -: 8]) begin errors++; $display("FAIL abc_beat %0d: got v=%b d=%h expected v=1 d=%h", b, m_tvalid, m_tdata, abc[23-8*b -: 8]); end
      checks++; if (m_tlast !== (b == 2)) begin errors++; $display("FAIL abc_tlast beat %0d: got %b", b, m_tlast); end
      if (b == 0) begin
        checks++; if (m_tid !== 32'd111) begin errors++; $display("FAIL abc_tid: got %0d expected 111", m_tid); end
      end
      tick();
    end
    s_tvalid = 4'b0000;
    c_ovalid = 1'b1; c_oid = 32'd111; c_olen = 61'd3; c_osha = ABC_SHA;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin errors++; $display("FAIL abc_back_idle: got v=%b rdy=%b expected 0/0000", m_tvalid, s_tready); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL abc_result_early: r_valid got %b expected 0", r_valid); end
    tick();
    c_ovalid = 1'b0;
    #1;
    checks++; if (r_valid !== 1'b1 || r_src !== 2'd1) begin errors++; $display("FAIL abc_result_route: got v=%b src=%0d expected v=1 src=1", r_valid, r_src); end
    checks++; if (r_len !== 61'd3 || r_id !== 32'd111) begin errors++; $display("FAIL abc_result_len_id: got len=%0d id=%0d expected 3/111", r_len, r_id); end
    checks++; if (r_sha !== ABC_SHA) begin errors++; $display("FAIL abc_result_sha: got %h expected %h", r_sha, ABC_SHA); end
    tick();
    #1;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL abc_result_one_cycle: r_valid got %b expected 0", r_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] bc, hs, exp_rdy;
    logic       exp_rv;
    int         ph, msg, req;
    do_reset();
    bc = 4'b0000; s_tvalid = 4'hF;
    for (int k = 0; k < 15; k++) begin
      ph = k % 3; msg = k / 3; req = msg % 4;
      for (int i = 0; i < 4; i++) begin
        s_tdata[i*8 +: 8] = 8'(i * 16) + {7'd0, bc[i]};
        s_tlast[i]        = bc[i];
      end
      c_ovalid = (ph == 0 && msg >= 1);
      c_oid = 32'(k); c_olen = 61'd2; c_osha = 256'(k);
      #1;
      exp_rdy = (ph == 0) ? 4'b0000 : 4'(1 << req);
      checks++; if (s_tready !== exp_rdy) begin errors++; $display("FAIL rr_s_tready cycle %0d: got %b expected %b", k, s_tready, exp_rdy); end
      checks++; if (m_tvalid !== (ph != 0)) begin errors++; $display("FAIL rr_m_tvalid cycle %0d: got %b", k, m_tvalid); end
      if (ph != 0) begin
        checks++; if (m_tdata !== 8'(req * 16 + ph - 1) || m_tlast !== (ph == 2) || m_tid !== 32'(100 + req)) begin
          errors++; $display("FAIL rr_beat cycle %0d: got d=%h l=%b id=%0d expected d=%h l=%b id=%0d", k, m_tdata, m_tlast, m_tid, 8'(req * 16 + ph - 1), (ph == 2), 100 + req);
        end
      end
      exp_rv = (ph == 1 && msg >= 1);
      checks++; if (r_valid !== exp_rv) begin errors++; $display("FAIL rr_r_valid cycle %0d: got %b expected %b", k, r_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (r_src !== 2'((msg - 1) % 4)) begin errors++; $display("FAIL rr_r_src cycle %0d: got %0d expected %0d", k, r_src, (msg - 1) % 4); end
      end
      hs = s_tvalid & s_tready;
      tick();
      bc = bc ^ hs;
    end
    s_tvalid = 4'b0000; c_ovalid = 1'b0;
  endtask

  task automatic test_tag_full();
    logic [3:0] exp_rdy;
    do_reset();
    s_tvalid = 4'hF; s_tlast = 4'hF; s_tdata = {8'h3A, 8'h2A, 8'h1A, 8'h0A};
    for (int k = 0; k < 11; k++) begin
      c_ovalid = (k == 10); c_oid = 32'd5; c_olen = 61'd1; c_osha = 256'd9;
      #1;
      exp_rdy = (k % 2 == 1 && k <= 7) ? 4'(1 << (k / 2)) : 4'b0000;
      checks++; if (s_tready !== exp_rdy) begin errors++; $display("FAIL full_s_tready cycle %0d: got %b expected %b", k, s_tready, exp_rdy); end
      tick();
    end
    c_ovalid = 1'b0;
    #1;
    checks++; if (r_valid !== 1'b1 || r_src !== 2'd0) begin errors++; $display("FAIL full_pop_route: got v=%b src=%0d expected 1/0", r_valid, r_src); end
    checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL full_regrant_idle: got %b expected 0000", s_tready); end
    tick();
    #1;
    checks++; if (s_tready !== 4'b0001 || m_tdata !== 8'h0A) begin errors++; $display("FAIL full_fifth_grant: got rdy=%b d=%h expected 0001/0a", s_tready, m_tdata); end
    s_tvalid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    s_tvalid = 4'b1000; s_tlast = 4'b0000; s_tdata[31:24] = 8'h30; m_tready = 1'b0;
    tick();
    #1;
    checks++; if (m_tvalid !== 1'b1 || s_tready !== 4'b0000 || m_tdata !== 8'h30) begin errors++; $display("FAIL bp_stall: got v=%b rdy=%b d=%h expected 1/0000/30", m_tvalid, s_tready, m_tdata); end
    tick();
    m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 4'b1000) begin errors++; $display("FAIL bp_release: got %b expected 1000", s_tready); end
    tick();
    s_tvalid = 4'b0010; s_tdata[31:24] = 8'h31; s_tlast[3] = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b1000) begin errors++; $display("FAIL bp_gap_keeps_grant: got v=%b rdy=%b expected 0/1000", m_tvalid, s_tready); end
    tick();
    s_tvalid = 4'b1010;
    #1;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h31 || m_tlast !== 1'b1) begin errors++; $display("FAIL bp_last_beat: got v=%b d=%h l=%b expected 1/31/1", m_tvalid, m_tdata, m_tlast); end
    tick();
    s_tvalid = 4'b0010; s_tlast[1] = 1'b1;
    tick();
    #1;
    checks++; if (s_tready !== 4'b0010) begin errors++; $display("FAIL bp_wrap_grant: got %b expected 0010", s_tready); end
    s_tvalid = 4'b0000;
  endtask

  task automatic test_orphan_result();
    do_reset();
    c_ovalid = 1'b1; c_oid = 32'hDEAD; c_olen = 61'd7; c_osha = 256'd1;
    #1;
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL orphan_err_early: got %b expected 0", tag_err); end
    tick();
    c_ovalid = 1'b0;
    #1;
    checks++; if (r_valid !== 1'b1 || r_src !== 2'd0 || r_len !== 61'd7) begin errors++; $display("FAIL orphan_result: got v=%b src=%0d len=%0d expected 1/0/7", r_valid, r_src, r_len); end
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL orphan_err_set: got %b expected 1", tag_err); end
    tick(); tick();
    #1;
    checks++; if (r_valid !== 1'b0 || tag_err !== 1'b1) begin errors++; $display("FAIL orphan_err_sticky: got v=%b err=%b expected 0/1", r_valid, tag_err); end
    rstn = 1'b0;
    #1;
    checks++; if (tag_err !== 1'b0 || r_len !== 61'd0) begin errors++; $display("FAIL orphan_err_clear: got err=%b len=%0d expected 0/0", tag_err, r_len); end
    rstn = 1'b1;
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    s_tvalid = 4'b0010; s_tlast = 4'b0010; s_tdata = 32'h20_0D_05_01;
    tick();
    #1;
    checks++; if (s_tready !== 4'b0010) begin errors++; $display("FAIL midrst_pre_msg: got %b expected 0010", s_tready); end
    tick();
    s_tvalid = 4'b0100; s_tlast = 4'b0000;
    tick();
    #1;
    checks++; if (m_tvalid !== 1'b1 || s_tready !== 4'b0100) begin errors++; $display("FAIL midrst_grant2: got v=%b rdy=%b expected 1/0100", m_tvalid, s_tready); end
    tick();
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin errors++; $display("FAIL midrst_async: got v=%b rdy=%b expected 0/0000", m_tvalid, s_tready); end
    s_tvalid = 4'b0101;
    tick();
    rstn = 1'b1;
    tick();
    #1;
    checks++; if (s_tready !== 4'b0001 || m_tdata !== 8'h01) begin errors++; $display("FAIL midrst_restart_req0: got rdy=%b d=%h expected 0001/01", s_tready, m_tdata); end
    s_tvalid = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_abc();
    test_round_robin();
    test_tag_full();
    test_backpressure();
    test_orphan_result();
    test_reset_mid_message();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
